fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage and architectural PC register for the RV32I core. It holds the current PC and issues one request at a time to instruction memory over a valid/ready port. It captures the returned word and presents it with its PC to decode/execute. When the consumer accepts an instruction, it loads the next PC that the PC-control logic computed for that instruction.

## Interface
- RESET_PC, default 32'h8000_0000: PC loaded on reset; must be 4-byte aligned.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- NewPC  in  32  next PC from PC control, computed from CurPC and the presented Inst; sampled only on the accept cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  request address, equal to CurPC.
- imem_resp_valid  in  1  one-cycle pulse carrying read data.
- imem_resp_data  in  32  instruction word.
- InstValid  out  1  Inst/CurPC are valid for the consumer.
- InstReady  in  1  consumer accepts; accept = InstValid & InstReady.
- Inst  out  32  registered fetched instruction.
- CurPC  out  32  PC of Inst; also drives PC control.
- InstAddrMisaligned  out  1  sticky fault flag.
- FaultPC  out  32  offending NewPC, valid while InstAddrMisaligned=1.
- RetireCount  out  32  number of accepts since reset.

## Operation
- FSM states: REQ, WAIT, HOLD, FAULT.
- REQ:
  - imem_req_valid=1 and imem_addr=CurPC.
  - If imem_req_ready=1, go to WAIT.
  - Otherwise stay in REQ, holding the address stable.
- WAIT:
  - When imem_resp_valid=1, set Inst <= imem_resp_data and go to HOLD.
  - imem_req_valid=0 in this state.
- HOLD:
  - InstValid=1; Inst and CurPC are held stable until accept.
  - On accept with NewPC[1:0]==0: PC <= NewPC, RetireCount += 1, go to REQ.
  - On accept with NewPC[1:0]!=0: FaultPC <= NewPC, RetireCount += 1, PC unchanged, go to FAULT.
- FAULT:
  - InstAddrMisaligned=1; no requests; InstValid=0.
  - Leaves only via rst.
- Responses arriving in REQ, HOLD or FAULT are ignored and do not change Inst.
- At most one request is outstanding. The memory side shares rst and discards any in-flight read on reset.
- RetireCount is 32-bit unsigned and wraps from 32'hFFFF_FFFF to 0.
- NewPC is not range-checked. Only bits [1:0] are checked; bit 1 set is a fault because the core has no C extension.

## Timing
- Reset: registers update on the clk edge where rst=1.
  - After that edge: CurPC=RESET_PC, state=REQ, Inst=32'h0000_0013 (NOP), InstValid=0, InstAddrMisaligned=0, FaultPC=0, RetireCount=0.
  - While rst=1, imem_req_valid is forced to 0.
- First request is asserted in the first cycle with rst=0.
- Zero-wait memory with InstReady held high:
  - REQ handshake in cycle t.
  - Response in t+1 (earliest allowed).
  - InstValid=1 in t+2, accept in t+2.
  - Next REQ in t+3; 3 cycles per instruction.
- Request wait states extend REQ and response wait states extend WAIT, each by exactly the stall length.
- Consumer stall extends HOLD; Inst and CurPC do not change during it.
- A response in the same cycle as the request handshake is illegal. The bench must not drive it; the DUT behaviour is unspecified.
- Reset in any state, including WAIT or FAULT, takes priority over every other event that cycle.

## Test plan
- Reset then idle memory: rst high 2 cycles → imem_req_valid=0 during reset; in the first cycle after, imem_req_valid=1 and imem_addr=32'h8000_0000; all other outputs at their reset values.
- Sequential fetch, zero-wait memory, InstReady=1, NewPC=CurPC+4, data = address: → InstValid=1 every 3rd cycle with Inst=32'h8000_0000, then 32'h8000_0004, then 32'h8000_0008; RetireCount=3 after three accepts.
- Stalls: imem_req_ready low 2 cycles, response delayed 3 cycles, InstReady low 4 cycles → imem_addr stable through the request stall, Inst stable through the consumer stall, each instruction accepted exactly once, no lost or duplicate fetches.
- Jump: in HOLD with CurPC=32'h8000_0010, drive NewPC=32'h8000_0100 on accept → next imem_addr=32'h8000_0100.
- Misaligned target: accept with NewPC=32'h8000_0102 → state FAULT, InstAddrMisaligned=1, FaultPC=32'h8000_0102, no further requests; then rst → CurPC=32'h8000_0000 and fetching resumes.
- Reset mid-WAIT, with stale-response checks: assert rst while in WAIT; separately, inject imem_resp_valid while in HOLD → in both cases Inst is unchanged by the stray data and the next fetch is from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the architectural PC, issues one imem read at a time,
// and holds the fetched word for the consumer until it is accepted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NewPC,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Inst,
  output logic [31:0] CurPC,
  output logic        InstAddrMisaligned,
  output logic [31:0] FaultPC,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] fault_pc_r;
  logic [31:0] retire_r;
  logic        accept_s;
  logic        misaligned_s;

  assign accept_s     = (state_r == HOLD) && InstReady;
  assign misaligned_s = (NewPC[1:0] != 2'b00);

  // next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      REQ: begin
        if (imem_req_ready) state_s = WAIT;
        else                state_s = REQ;
      end
      WAIT: begin
        if (imem_resp_valid) state_s = HOLD;
        else                 state_s = WAIT;
      end
      HOLD: begin
        if (accept_s) state_s = misaligned_s ? FAULT : REQ;
        else          state_s = HOLD;
      end
      FAULT:   state_s = FAULT;
      default: state_s = REQ;
    endcase
  end

  // state, PC, fetched word, fault capture and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= REQ;
      pc_r       <= RESET_PC;
      inst_r     <= NOP;
      fault_pc_r <= 32'h0000_0000;
      retire_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      // only a response in WAIT is ours; anything else is stale and dropped
      if ((state_r == WAIT) && imem_resp_valid) begin
        inst_r <= imem_resp_data;
      end
      if (accept_s) begin
        retire_r <= retire_r + 32'd1;
        if (misaligned_s) fault_pc_r <= NewPC;
        else              pc_r       <= NewPC;
      end
    end
  end

  assign imem_req_valid     = (state_r == REQ) && !rst;
  assign imem_addr          = pc_r;
  assign InstValid          = (state_r == HOLD);
  assign Inst               = inst_r;
  assign CurPC              = pc_r;
  assign InstAddrMisaligned = (state_r == FAULT);
  assign FaultPC            = fault_pc_r;
  assign RetireCount        = retire_r;

endmodule
